// File: rtl/func_op_pkg.sv
// Shared types and the bitwise stage of f(a,b) = (a OP b) + b.
// The bitwise helper works on one bit so it serves any operand width.
package func_op_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'd0,
        OP_AND = 2'd1,
        OP_XOR = 2'd2,
        OP_ACC = 2'd3
    } op_mode_e;

    // Accumulate mode reuses the OR operation for its inner term.
    function automatic logic func_op_logic(input logic a, input logic b, input op_mode_e mode);
        logic r;
        case (mode)
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_ACC:  r = a | b;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/func_op_stage.sv
// Generic valid/ready register slice; the surrounding logic decides when it loads.
module func_op_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    // Data only moves on a valid beat so a drained stage keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_data  <= {WIDTH{1'b0}};
        end else if (load) begin
            q_valid <= d_valid;
            if (d_valid) begin
                q_data <= d_data;
            end
        end
    end

endmodule

// File: rtl/func_op_pipe.sv
// Two-stage pipelined (a OP b) + b with running accumulate mode and
// valid/ready flow control on both sides.
module func_op_pipe
    import func_op_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
);

    localparam int S1_W = 2 * WIDTH + 2;
    localparam int S2_W = WIDTH + 1;

    logic [WIDTH-1:0] logic_s;
    logic [S1_W-1:0]  s1_in_s;
    logic [S1_W-1:0]  s1_data_s;
    logic             s1_valid_s;
    logic [S2_W-1:0]  s2_data_s;
    logic             s2_valid_s;
    logic             s2_load_s;
    logic             s1_adv_s;
    op_mode_e         s1_mode_s;
    logic [WIDTH-1:0] s1_logic_s;
    logic [WIDTH-1:0] s1_b_s;
    logic [WIDTH:0]   inner_s;
    logic [WIDTH-1:0] acc_base_s;
    logic [WIDTH:0]   acc_sum_s;
    logic [WIDTH:0]   result_s;
    logic             acc_load_s;
    logic [WIDTH-1:0] acc_r;

    assign s2_load_s = !s2_valid_s | out_ready;
    assign s1_adv_s  = !s1_valid_s | s2_load_s;
    assign in_ready  = s1_adv_s;

    // Bitwise stage, applied bit by bit through the shared helper.
    always_comb begin
        logic_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            logic_s[i] = func_op_logic(in_a[i], in_b[i], op_mode_e'(in_mode));
        end
    end

    assign s1_in_s = {in_mode, logic_s, in_b};

    func_op_stage #(.WIDTH(S1_W)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .load    (s1_adv_s),
        .d_valid (in_valid),
        .d_data  (s1_in_s),
        .q_valid (s1_valid_s),
        .q_data  (s1_data_s)
    );

    assign s1_mode_s  = op_mode_e'(s1_data_s[S1_W-1 -: 2]);
    assign s1_logic_s = s1_data_s[2*WIDTH-1:WIDTH];
    assign s1_b_s     = s1_data_s[WIDTH-1:0];

    // Final add; a clear in the same cycle zeroes the accumulator operand first.
    always_comb begin
        inner_s = {1'b0, s1_logic_s} + {1'b0, s1_b_s};
        if (acc_clr) begin
            acc_base_s = {WIDTH{1'b0}};
        end else begin
            acc_base_s = acc_r;
        end
        acc_sum_s = {1'b0, acc_base_s} + {1'b0, inner_s[WIDTH-1:0]};
        if (s1_mode_s == OP_ACC) begin
            result_s = acc_sum_s;
        end else begin
            result_s = inner_s;
        end
    end

    assign acc_load_s = s2_load_s & s1_valid_s & (s1_mode_s == OP_ACC);

    // Accumulator follows the S2 load of accumulate beats; otherwise clear or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {WIDTH{1'b0}};
        end else if (acc_load_s) begin
            acc_r <= acc_sum_s[WIDTH-1:0];
        end else if (acc_clr) begin
            acc_r <= {WIDTH{1'b0}};
        end
    end

    func_op_stage #(.WIDTH(S2_W)) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .load    (s2_load_s),
        .d_valid (s1_valid_s),
        .d_data  (result_s),
        .q_valid (s2_valid_s),
        .q_data  (s2_data_s)
    );

    assign out_valid = s2_valid_s;
    assign out_data  = s2_data_s[WIDTH-1:0];
    assign out_carry = s2_data_s[WIDTH];

endmodule

// File: tb/tb_func_op_pipe.sv
// Directed bench for func_op_pipe with hand-computed expected values.
module tb_func_op_pipe;
    import func_op_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [1:0]  in_mode;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_carry;

    int checks = 0;
    int errors = 0;

    func_op_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 16'h0000;
        in_b      = 16'h0000;
        in_mode   = 2'd0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        chk("rst_carry", {31'd0, out_carry}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Mode 0 with latency check
        drive(16'h00F0, 16'h0F0F, 2'd0);
        tick();
        in_valid = 1'b0;
        chk("lat_1cyc_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("or_valid", {31'd0, out_valid}, 32'd1);
        chk("or_data", {16'd0, out_data}, 32'h1F0E);
        chk("or_carry", {31'd0, out_carry}, 32'd0);
        tick();
        chk("or_drained", {31'd0, out_valid}, 32'd0);

        // Modes 1 and 2 back-to-back
        drive(16'h00F0, 16'h0F0F, 2'd1);
        tick();
        drive(16'h00F0, 16'h0F0F, 2'd2);
        tick();
        in_valid = 1'b0;
        chk("and_data", {16'd0, out_data}, 32'h0F0F);
        chk("and_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("xor_data", {16'd0, out_data}, 32'h1F0E);
        chk("xor_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bb_drained", {31'd0, out_valid}, 32'd0);

        // Wraparound carry
        drive(16'hFFFF, 16'h0001, 2'd0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("wrap_data", {16'd0, out_data}, 32'h0000);
        chk("wrap_carry", {31'd0, out_carry}, 32'd1);
        tick();

        // Accumulate: 2, 4, 6, then clear alongside the fourth beat gives 2
        drive(16'h0000, 16'h0001, 2'd3);
        tick();
        tick();
        chk("acc1", {16'd0, out_data}, 32'd2);
        tick();
        chk("acc2", {16'd0, out_data}, 32'd4);
        tick();
        chk("acc3", {16'd0, out_data}, 32'd6);
        in_valid = 1'b0;
        acc_clr  = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("acc_clr_data", {16'd0, out_data}, 32'd2);
        chk("acc_clr_carry", {31'd0, out_carry}, 32'd0);
        tick();

        // Mode 0 beat leaves acc at 2; the next accumulate gives 4
        drive(16'h0001, 16'h0001, 2'd0);
        tick();
        drive(16'h0000, 16'h0001, 2'd3);
        tick();
        in_valid = 1'b0;
        chk("mix_or", {16'd0, out_data}, 32'd2);
        tick();
        chk("mix_acc", {16'd0, out_data}, 32'd4);
        tick();

        // Backpressure: two accepted, then stall with stable output
        out_ready = 1'b0;
        drive(16'h0001, 16'h0010, 2'd0);
        tick();
        chk("bp_ready_1", {31'd0, in_ready}, 32'd1);
        drive(16'h0100, 16'h0100, 2'd1);
        tick();
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_data0", {16'd0, out_data}, 32'h0021);
        drive(16'h00FF, 16'h000F, 2'd2);
        tick();
        tick();
        chk("bp_stable", {16'd0, out_data}, 32'h0021);
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_data1", {16'd0, out_data}, 32'h0200);
        drive(16'h8000, 16'h8000, 2'd0);
        tick();
        in_valid = 1'b0;
        chk("bp_data2", {16'd0, out_data}, 32'h00FF);
        tick();
        chk("bp_data3", {16'd0, out_data}, 32'h0000);
        chk("bp_carry3", {31'd0, out_carry}, 32'd1);
        tick();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset with two accumulate beats in flight
        drive(16'h0000, 16'h0001, 2'd3);
        tick();
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_data", {16'd0, out_data}, 32'd6);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {16'd0, out_data}, 32'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        tick();
        chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
        drive(16'h0000, 16'h0001, 2'd3);
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_rst_acc", {16'd0, out_data}, 32'd2);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("post_rst_drained", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
